// File: rtl/riscv_store_buffer_if.sv
// Core-side and memory-side signal bundle for riscv_store_buffer.
// master: the core/memory environment; slave: the store buffer itself.
interface riscv_store_buffer_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
);
   logic          CORE_WR_EN;
   logic          CORE_RD_EN;
   logic [AW-1:0] CORE_ADDR;
   logic [DW-1:0] CORE_WDATA;
   logic [DW-1:0] CORE_RDATA;
   logic          CORE_STALL;
   logic          MEM_GNT;
   logic          MEM_WR_EN;
   logic          MEM_RD_EN;
   logic [AW-1:0] MEM_ADDR;
   logic [DW-1:0] MEM_WDATA;
   logic [DW-1:0] MEM_RDATA;
   logic          FLUSH;
   logic          EMPTY;

   modport master (
      output CORE_WR_EN, CORE_RD_EN, CORE_ADDR, CORE_WDATA, MEM_GNT, MEM_RDATA, FLUSH,
      input  CORE_RDATA, CORE_STALL, MEM_WR_EN, MEM_RD_EN, MEM_ADDR, MEM_WDATA, EMPTY
   );

   modport slave (
      input  CORE_WR_EN, CORE_RD_EN, CORE_ADDR, CORE_WDATA, MEM_GNT, MEM_RDATA, FLUSH,
      output CORE_RDATA, CORE_STALL, MEM_WR_EN, MEM_RD_EN, MEM_ADDR, MEM_WDATA, EMPTY
   );
endinterface

// File: rtl/riscv_store_buffer.sv
// Word-granular posted-store FIFO between the core data port and main memory.
// Stores retire into the buffer in one cycle and drain on cycles without a load;
// loads take priority and forward from the youngest matching buffered store.
// Optional macro STORE_BUF_STATS_EN adds saturating stall/forward/drain counters.
module riscv_store_buffer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 32,
   parameter int unsigned DW    = 32
) (
   input  logic                  CLK,
   input  logic                  RSTN,
   riscv_store_buffer_if.slave   bus
`ifdef STORE_BUF_STATS_EN
   ,
   output logic [31:0]           STAT_STALLS,
   output logic [31:0]           STAT_FWDS,
   output logic [31:0]           STAT_DRAINS
`endif
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [AW-1:0]    addr_q [DEPTH];
   logic [DW-1:0]    data_q [DEPTH];
   logic [PTR_W-1:0] head_q;
   logic [PTR_W-1:0] tail_q;
   logic [CNT_W-1:0] count_q;

   logic             load_c;
   logic             full_c;
   logic             drain_c;
   logic             accept_c;
   logic             hit_c;
   logic [DW-1:0]    fwd_data_c;
   logic [PTR_W-1:0] idx_c;

   // A simultaneous store and load is illegal; the store wins and the load is dropped.
   assign load_c   = bus.CORE_RD_EN & ~bus.CORE_WR_EN;
   assign full_c   = (count_q == CNT_W'(DEPTH));
   assign drain_c  = ~load_c & (count_q != '0) & bus.MEM_GNT;
   assign accept_c = bus.CORE_WR_EN & ~bus.FLUSH & (~full_c | drain_c);

   // Forwarding search: walk oldest to youngest so the last match is the youngest.
   always_comb begin
      hit_c      = 1'b0;
      fwd_data_c = '0;
      idx_c      = head_q;
      for (int k = 0; k < int'(DEPTH); k++) begin
         idx_c = head_q + PTR_W'(k);
         if ((CNT_W'(k) < count_q) &&
             (addr_q[idx_c][AW-1:2] == bus.CORE_ADDR[AW-1:2])) begin
            hit_c      = 1'b1;
            fwd_data_c = data_q[idx_c];
         end
      end
   end

   // Core and memory port outputs for the current cycle.
   always_comb begin
      bus.MEM_WR_EN  = drain_c;
      bus.MEM_RD_EN  = load_c & bus.MEM_GNT;
      bus.MEM_ADDR   = '0;
      bus.MEM_WDATA  = '0;
      bus.CORE_RDATA = '0;
      bus.CORE_STALL = 1'b0;
      bus.EMPTY      = (count_q == '0);
      if (load_c) begin
         bus.MEM_ADDR   = bus.CORE_ADDR;
         bus.CORE_RDATA = hit_c ? fwd_data_c : bus.MEM_RDATA;
         bus.CORE_STALL = ~hit_c & ~bus.MEM_GNT;
      end else if (drain_c) begin
         bus.MEM_ADDR  = addr_q[head_q];
         bus.MEM_WDATA = data_q[head_q];
      end
      if (bus.CORE_WR_EN) begin
         bus.CORE_STALL = ~accept_c;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (drain_c)  head_q <= head_q + PTR_W'(1);
         if (accept_c) tail_q <= tail_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(accept_c) - CNT_W'(drain_c);
      end
   end

   // Entry storage; contents are only meaningful inside the head..tail window.
   always_ff @(posedge CLK) begin
      if (RSTN && accept_c) begin
         addr_q[tail_q] <= bus.CORE_ADDR;
         data_q[tail_q] <= bus.CORE_WDATA;
      end
   end

`ifdef STORE_BUF_STATS_EN
   // Saturating event counters.
   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         STAT_STALLS <= '0;
         STAT_FWDS   <= '0;
         STAT_DRAINS <= '0;
      end else begin
         if (bus.CORE_STALL && (STAT_STALLS != '1)) STAT_STALLS <= STAT_STALLS + 32'd1;
         if (load_c && hit_c && (STAT_FWDS != '1))  STAT_FWDS   <= STAT_FWDS + 32'd1;
         if (drain_c && (STAT_DRAINS != '1))        STAT_DRAINS <= STAT_DRAINS + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_riscv_store_buffer.sv
// Self-checking bench for riscv_store_buffer: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_riscv_store_buffer;

   localparam int unsigned DEPTH = 4;

   logic clk;
   logic rstn;
   int   errors;
   int   checks;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_stalls, m_fwds, m_drains;

   riscv_store_buffer_if #(.AW(32), .DW(32)) bus ();

`ifdef STORE_BUF_STATS_EN
   logic [31:0] stat_stalls, stat_fwds, stat_drains;
`endif

   riscv_store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
      .CLK         (clk),
      .RSTN        (rstn),
      .bus         (bus)
`ifdef STORE_BUF_STATS_EN
      ,
      .STAT_STALLS (stat_stalls),
      .STAT_FWDS   (stat_fwds),
      .STAT_DRAINS (stat_drains)
`endif
   );

   // Memory read data is a fixed function of the address.
   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
   endfunction

   assign bus.MEM_RDATA = mem_fn(bus.MEM_ADDR);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Apply one cycle of inputs, compare against the model, then advance the clock.
   task automatic step(input logic rst_n, input logic wr, input logic rd,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic gnt, input logic fl);
      logic        load, drain, full, accept, hit;
      logic [31:0] fwd, e_addr, e_wdata, e_rdata;
      logic        e_stall;
      rstn           = rst_n;
      bus.CORE_WR_EN = wr;
      bus.CORE_RD_EN = rd;
      bus.CORE_ADDR  = addr;
      bus.CORE_WDATA = wdata;
      bus.MEM_GNT    = gnt;
      bus.FLUSH      = fl;
      #2;
      load   = rd && !wr;
      drain  = !load && (mq.size() > 0) && gnt;
      full   = (mq.size() == DEPTH);
      accept = wr && !fl && (!full || drain);
      hit    = 1'b0;
      fwd    = '0;
      for (int i = mq.size() - 1; i >= 0; i--) begin
         if (!hit && (mq[i].a[31:2] == addr[31:2])) begin
            hit = 1'b1;
            fwd = mq[i].d;
         end
      end
      e_addr  = load ? addr : (drain ? mq[0].a : 32'h0);
      e_wdata = drain ? mq[0].d : 32'h0;
      e_rdata = load ? (hit ? fwd : mem_fn(addr)) : 32'h0;
      e_stall = wr ? !accept : (load ? (!hit && !gnt) : 1'b0);
      if (rst_n) begin
         check_eq("mem_wr_en",  32'(bus.MEM_WR_EN),  32'(drain));
         check_eq("mem_rd_en",  32'(bus.MEM_RD_EN),  32'(load && gnt));
         check_eq("mem_addr",   bus.MEM_ADDR,        e_addr);
         check_eq("mem_wdata",  bus.MEM_WDATA,       e_wdata);
         check_eq("core_rdata", bus.CORE_RDATA,      e_rdata);
         check_eq("core_stall", 32'(bus.CORE_STALL), 32'(e_stall));
         check_eq("empty",      32'(bus.EMPTY),      32'(mq.size() == 0));
`ifdef STORE_BUF_STATS_EN
         check_eq("stat_stalls", stat_stalls, m_stalls);
         check_eq("stat_fwds",   stat_fwds,   m_fwds);
         check_eq("stat_drains", stat_drains, m_drains);
`endif
      end
      if (!rst_n) begin
         mq.delete();
         m_stalls = '0;
         m_fwds   = '0;
         m_drains = '0;
      end else begin
         if (e_stall && m_stalls != '1)        m_stalls++;
         if (load && hit && m_fwds != '1)      m_fwds++;
         if (drain && m_drains != '1)          m_drains++;
         if (drain)  void'(mq.pop_front());
         if (accept) mq.push_back('{a: addr, d: wdata});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic gnt);
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, gnt, 1'b0);
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic gnt, input logic fl);
      step(1'b1, 1'b1, 1'b0, a, d, gnt, fl);
   endtask

   task automatic load(input logic [31:0] a, input logic gnt);
      step(1'b1, 1'b0, 1'b1, a, 32'h0, gnt, 1'b0);
   endtask

   initial begin
      errors   = 0;
      checks   = 0;
      m_stalls = '0;
      m_fwds   = '0;
      m_drains = '0;
      rstn     = 1'b0;
      @(posedge clk);
      #1;
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

      // Reset state
      idle(1'b0);

      // Single store drained on the following cycle
      store(32'h1000, 32'h11, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);

      // Fill to DEPTH, stall the fifth store, then accept it alongside a drain
      for (int i = 0; i < 4; i++) store(32'h10 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0, 1'b0);
      store(32'h50, 32'hA5, 1'b0, 1'b0);
      store(32'h50, 32'hA5, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) idle(1'b1);

      // Forwarding picks the youngest of two stores to the same word
      store(32'h20, 32'hAA, 1'b0, 1'b0);
      store(32'h20, 32'hBB, 1'b0, 1'b0);
      load(32'h22, 1'b0);
      load(32'h24, 1'b1);
      for (int i = 0; i < 3; i++) idle(1'b1);

      // Load miss stalls until the memory grants
      load(32'h40, 1'b0);
      load(32'h40, 1'b0);
      load(32'h40, 1'b1);

      // Flush drains in order while new stores stall
      for (int i = 0; i < 3; i++) store(32'h60 + 32'(4 * i), 32'hC0 + 32'(i), 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) store(32'h80, 32'hDD, 1'b1, 1'b1);
      idle(1'b1);

      // Reset in the middle of draining discards the remaining entries
      for (int i = 0; i < 3; i++) store(32'h90 + 32'(4 * i), 32'hE0 + 32'(i), 1'b0, 1'b0);
      idle(1'b1);
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      idle(1'b1);

      // Random traffic on a small address window to exercise hits and full conditions
      for (int n = 0; n < 2000; n++) begin
         int unsigned r;
         logic        wr, rd, gnt, fl, rst_n;
         logic [31:0] a;
         r     = $urandom_range(0, 9);
         wr    = (r < 4);
         rd    = (r >= 4) && (r < 7);
         a     = 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
         gnt   = ($urandom_range(0, 2) != 0);
         fl    = ($urandom_range(0, 15) == 0);
         rst_n = ($urandom_range(0, 299) != 0);
         step(rst_n, wr, rd, a, $urandom, gnt, fl);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
